// File: rtl/bcd_to_binary_converter_pkg.sv
// ============================================================================
// Module  : bcd_to_binary_converter_pkg
// Brief   : Shared DCF77 decode constants and BCD converter state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_to_binary_converter_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [6:0] BCD_TEN       = 7'd10;

  localparam int unsigned MINUTE_MAX = 59;
  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned DAY_MAX    = 31;
  localparam int unsigned MONTH_MAX  = 12;
  localparam int unsigned YEAR_MAX   = 99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } conv_state_t;

endpackage : bcd_to_binary_converter_pkg

`default_nettype wire

// File: rtl/bcd_to_binary_converter.sv
// ============================================================================
// Module  : bcd_to_binary_converter
// Brief   : Two-digit packed BCD to 7-bit binary, one add-ten cycle per tens unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_binary_converter
  import bcd_to_binary_converter_pkg::*;
#(
  parameter int unsigned MAX_VALUE = 99
) (
  input  logic       clk_in,
  input  logic       GSR,
  input  logic       flag_sincro,
  input  logic [7:0] cifre,
  output logic [6:0] numero,
  output logic       flag_pronto,
  output logic       flag_errore,
  output logic       busy
);

  localparam logic [6:0] c_MAX = 7'(MAX_VALUE);

  conv_state_t state_q;
  logic [3:0]  tens_q;
  logic [6:0]  acc_q;
  logic        dig_err_q;
  logic [6:0]  numero_q;
  logic        pronto_q;
  logic        errore_q;
  logic        busy_q;

  logic        dig_err_d;

  assign dig_err_d = (cifre[3:0] > BCD_DIGIT_MAX) || (cifre[7:4] > BCD_DIGIT_MAX);

  always_ff @(posedge clk_in) begin
    if (GSR) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      acc_q     <= 7'd0;
      dig_err_q <= 1'b0;
      numero_q  <= 7'd0;
      pronto_q  <= 1'b0;
      errore_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      // A new start wins over whatever the FSM would do on this edge.
      if (flag_sincro) begin
        tens_q    <= cifre[7:4];
        acc_q     <= {3'b000, cifre[3:0]};
        dig_err_q <= dig_err_d;
        errore_q  <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= dig_err_d ? FINISH : ACCUM;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          ACCUM: begin
            if (tens_q != 4'd0) begin
              acc_q  <= acc_q + BCD_TEN;
              tens_q <= tens_q - 4'd1;
            end else begin
              state_q <= FINISH;
            end
          end
          FINISH: begin
            if (dig_err_q || (acc_q > c_MAX)) begin
              errore_q <= 1'b1;
            end else begin
              numero_q <= acc_q;
            end
            pronto_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign numero      = numero_q;
  assign flag_pronto = pronto_q;
  assign flag_errore = errore_q;
  assign busy        = busy_q;

endmodule : bcd_to_binary_converter

`default_nettype wire

// File: tb/tb_bcd_to_binary_converter.sv
// ============================================================================
// Module  : tb_bcd_to_binary_converter
// Brief   : Randomised self-checking bench, three instances (limits 59/23/99).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_converter;
  import bcd_to_binary_converter_pkg::*;

  logic       clk_in;
  logic       GSR;
  logic       flag_sincro;
  logic [7:0] cifre;

  logic [6:0] numero_w [3];
  logic       pronto_w [3];
  logic       errore_w [3];
  logic       busy_w   [3];

  int unsigned maxv    [3] = '{MINUTE_MAX, HOUR_MAX, YEAR_MAX};
  int unsigned exp_num [3];

  int checks   = 0;
  int failures = 0;

  bcd_to_binary_converter #(.MAX_VALUE(MINUTE_MAX)) u_dut_min (
    .clk_in(clk_in), .GSR(GSR), .flag_sincro(flag_sincro), .cifre(cifre),
    .numero(numero_w[0]), .flag_pronto(pronto_w[0]), .flag_errore(errore_w[0]), .busy(busy_w[0])
  );

  bcd_to_binary_converter #(.MAX_VALUE(HOUR_MAX)) u_dut_hour (
    .clk_in(clk_in), .GSR(GSR), .flag_sincro(flag_sincro), .cifre(cifre),
    .numero(numero_w[1]), .flag_pronto(pronto_w[1]), .flag_errore(errore_w[1]), .busy(busy_w[1])
  );

  bcd_to_binary_converter #(.MAX_VALUE(YEAR_MAX)) u_dut_year (
    .clk_in(clk_in), .GSR(GSR), .flag_sincro(flag_sincro), .cifre(cifre),
    .numero(numero_w[2]), .flag_pronto(pronto_w[2]), .flag_errore(errore_w[2]), .busy(busy_w[2])
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_numero"}, numero_w[i], exp_num[i]);
      check_eq({tag, "_pronto"}, pronto_w[i], 0);
      check_eq({tag, "_busy"},   busy_w[i],   0);
    end
  endtask

  // Drives a capture edge, then scrambles cifre to show it is not re-read.
  task automatic start(input logic [7:0] v);
    flag_sincro = 1'b1;
    cifre       = v;
    @(posedge clk_in);
    #1;
    flag_sincro = 1'b0;
    cifre       = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      check_eq("cap_busy",   busy_w[i],   1);
      check_eq("cap_pronto", pronto_w[i], 0);
      check_eq("cap_errore", errore_w[i], 0);
      check_eq("cap_numero", numero_w[i], exp_num[i]);
    end
  endtask

  task automatic run_conv(input logic [7:0] v);
    int unsigned t, u, val, lat;
    bit          derr, err;
    t    = v[7:4];
    u    = v[3:0];
    derr = (t > 9) || (u > 9);
    val  = 10 * t + u;
    lat  = derr ? 1 : t + 2;
    start(v);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk_in);
      #1;
      for (int i = 0; i < 3; i++) begin
        check_eq("run_busy",   busy_w[i],   1);
        check_eq("run_pronto", pronto_w[i], 0);
      end
    end
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 3; i++) begin
      err = derr || (val > maxv[i]);
      if (!err) exp_num[i] = val;
      check_eq("done_pronto", pronto_w[i], 1);
      check_eq("done_busy",   busy_w[i],   0);
      check_eq("done_errore", errore_w[i], err ? 1 : 0);
      check_eq("done_numero", numero_w[i], exp_num[i]);
    end
  endtask

  task automatic idle_cycles(input int n);
    logic e [3];
    for (int i = 0; i < 3; i++) e[i] = errore_w[i];
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
      for (int i = 0; i < 3; i++) check_eq("hold_errore", errore_w[i], e[i] ? 1 : 0);
      check_idle_all("idle");
    end
  endtask

  initial begin
    logic [7:0] v;
    GSR         = 1'b1;
    flag_sincro = 1'b0;
    cifre       = 8'h00;
    for (int i = 0; i < 3; i++) exp_num[i] = 0;
    repeat (3) @(posedge clk_in);
    #1;
    GSR = 1'b0;
    @(posedge clk_in);
    #1;
    check_idle_all("reset");
    for (int i = 0; i < 3; i++) check_eq("reset_errore", errore_w[i], 0);

    // Directed cases from the plan, including digit and range errors.
    run_conv(8'h47);
    idle_cycles(1);
    run_conv(8'h00);
    run_conv(8'h99);
    run_conv(8'h3A);
    idle_cycles(2);
    run_conv(8'hB2);
    run_conv(8'h24);
    run_conv(8'h23);

    // Restart two cycles into a conversion.
    start(8'h58);
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 3; i++) check_eq("abort_pronto", pronto_w[i], 0);
    run_conv(8'h12);

    // Restart landing on the FINISH edge (T=0 -> FINISH at N+2).
    start(8'h05);
    @(posedge clk_in);
    #1;
    run_conv(8'h31);

    // Reset in the middle of accumulation.
    start(8'h75);
    repeat (2) @(posedge clk_in);
    #1;
    GSR = 1'b1;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 3; i++) exp_num[i] = 0;
    check_idle_all("gsr_mid");
    for (int i = 0; i < 3; i++) check_eq("gsr_mid_errore", errore_w[i], 0);
    GSR = 1'b0;
    idle_cycles(3);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) v = 8'($urandom);
      else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_conv(v);
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_to_binary_converter

`default_nettype wire

// File: doc/bcd_to_binary_converter.md
# bcd_to_binary_converter

Converts a two-digit packed BCD value (tens nibble, units nibble) into a 7-bit binary number. It uses an iterative add-ten loop: one cycle per tens unit. It sits on the DCF77 decode path, after the bit-field extractor: minute, hour, day, month and year fields arrive in BCD and are turned into binary for counting and comparison logic. Each digit and the final value are validated, so a corrupted telegram field is flagged instead of loaded.

## Interface
Parameters:
- MAX_VALUE, 99: largest legal result. Use 59 for minutes, 23 for hours, 31 for day and so on. Must be ≤ 99.

Ports:
- clk_in  input  1  system clock.
- GSR  input  1  reset. Synchronous and active-high: sampled only on the rising edge of clk_in, and clears all state.
- flag_sincro  input  1  start strobe. Sampled each rising edge. When high, `cifre` is captured.
- cifre  input  8  packed BCD input: [7:4] tens, [3:0] units.
- numero  output  7  last successfully converted binary value.
- flag_pronto  output  1  one-cycle pulse marking the end of a conversion, whether successful or failed.
- flag_errore  output  1  high when the last conversion failed. Held until the next accepted start.
- busy  output  1  high while a conversion is in progress.

## Operation
- States: IDLE, ACCUM, FINISH.
- IDLE: waits for flag_sincro.
- Capture, on an edge with flag_sincro=1, from any state:
  - tens_cnt ← cifre[7:4]
  - acc ← {3'b0, cifre[3:0]}
  - flag_errore ← 0
  - busy ← 1
- Digit check at capture:
  - If cifre[3:0] > 9 or cifre[7:4] > 9: set a digit-error marker and go to FINISH directly.
  - Otherwise go to ACCUM.
- ACCUM, per edge:
  - If tens_cnt ≠ 0: acc ← acc + 10 and tens_cnt ← tens_cnt − 1.
  - If tens_cnt = 0: go to FINISH.
- FINISH, one edge:
  - If digit error or acc > MAX_VALUE: flag_errore ← 1, numero unchanged.
  - Otherwise numero ← acc.
  - In both cases: flag_pronto ← 1 for one cycle, busy ← 0, next state IDLE.
- Arithmetic width:
  - acc is 7 bits. With valid digits the maximum is 99, so acc cannot overflow.
  - The MAX_VALUE comparison is unsigned, at 7 bits.
- Simultaneous events:
  - flag_sincro during ACCUM or FINISH aborts the current conversion and restarts with the new `cifre`.
  - An aborted conversion produces no flag_pronto and leaves numero untouched.
  - Restart takes priority over the FINISH update on the same edge.
- Reset, including mid-conversion, returns to IDLE with:
  - numero=0, flag_pronto=0, flag_errore=0, busy=0
  - acc=0, tens_cnt=0
- `cifre` is read only at capture, so changes afterwards have no effect.

## Timing
- Reset values: numero=7'd0, flag_pronto=0, flag_errore=0, busy=0, state IDLE.
- Let the capture edge be N and the tens digit be T:
  - busy is high from after edge N.
  - ACCUM occupies edges N+1 … N+T+1; the last of these sees tens_cnt=0.
  - FINISH is at edge N+T+2.
  - flag_pronto and the new numero are visible after edge N+T+2.
- Latency: T+2 cycles, from 2 (for 00–09) up to 11 (for 90–99).
- Digit error: FINISH is at edge N+1, so flag_pronto and flag_errore are high after edge N+1. Latency is 1 cycle.
- flag_pronto lasts exactly one cycle.
- flag_errore rises with flag_pronto and persists until the next capture edge.
- No back-pressure: a new start may be issued in the cycle flag_pronto is high.

## Structure
- Shared decode package holds:
  - BCD_DIGIT_MAX = 4'd9
  - BCD_TEN = 7'd10
  - the state encoding: IDLE=2'd0, ACCUM=2'd1, FINISH=2'd2
  - per-field MAX_VALUE constants: MINUTE_MAX=59, HOUR_MAX=23, DAY_MAX=31, MONTH_MAX=12, YEAR_MAX=99
- Single module, no sub-module. The digit check is two comparators inside the capture logic.
- One instance per DCF77 field, each with its own MAX_VALUE.

## Test plan
- GSR held 3 cycles, then released with flag_sincro=0 → numero=0, flag_pronto=0, flag_errore=0, busy=0.
- cifre=8'h47, MAX_VALUE=59, start at edge N → busy during edges N..N+5; after edge N+6: numero=47, flag_pronto=1 for one cycle, flag_errore=0.
- cifre=8'h00, then 8'h99 with MAX_VALUE=99 → numero=0 after 2 cycles; numero=99 after 11 cycles, no error.
- cifre=8'h3A → after 1 cycle: flag_pronto=1, flag_errore=1, numero keeps its previous value. cifre=8'hB2 behaves the same.
- cifre=8'h24 with MAX_VALUE=23 → flag_errore=1 after 4 cycles, numero unchanged. cifre=8'h23 → numero=23, no error.
- Start 8'h58, then a new start 8'h12 two cycles later → no pulse for 58; numero=12 three cycles after the second start. Separately, GSR asserted mid-ACCUM → all outputs 0 on the next edge, with no flag_pronto.
